// File: rtl/switch_debounce_scheduler.sv
// Shared-counter switch debouncer: a round-robin scheduler lends one stability counter to one changing switch at a time.
// Optional macro SW_EDGE_PULSE_EN enables registered press_o/release_o pulses; otherwise they are tied to 0.
module switch_debounce_scheduler #(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [NUM_SW-1:0]                      sw_i,
    output logic [NUM_SW-1:0]                      sw_o,
    output logic [NUM_SW-1:0]                      press_o,
    output logic [NUM_SW-1:0]                      release_o,
    output logic                                   busy_o,
    output logic [((NUM_SW > 2) ? $clog2(NUM_SW) : 1)-1:0] grant_o
);

    localparam int GW = (NUM_SW > 2) ? $clog2(NUM_SW) : 1;
    localparam int CW = $clog2(DEBOUNCE_LIMIT);

    typedef enum logic {SCAN, COUNT} fsm_e;

    // Handshake-free block: busy_o is the exposed FSM state (1 = COUNT); grant_o names the switch owning the counter.
    fsm_e              fsm_q, fsm_d;
    logic [NUM_SW-1:0] sync1_q, sync2_q;
    logic [NUM_SW-1:0] state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [NUM_SW-1:0] diff;
    logic              found;
    logic [GW-1:0]     pick;
    logic              accept, bounce;
    logic [GW-1:0]     next_ptr;

    assign diff = sync2_q ^ state_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // Circular priority search starting at the round-robin pointer.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_SW; i++) begin
            idx = (int'(ptr_q) + i) % NUM_SW;
            if (!found && diff[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign bounce   = (fsm_q == COUNT) && !diff[grant_q];
    assign accept   = (fsm_q == COUNT) && diff[grant_q] && (count_q == CW'(DEBOUNCE_LIMIT - 1));
    assign next_ptr = (grant_q == GW'(NUM_SW - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (fsm_q)
            SCAN: begin
                if (found) begin
                    grant_d = pick;
                    count_d = '0;
                    fsm_d   = COUNT;
                end
            end
            COUNT: begin
                if (bounce) begin
                    ptr_d = next_ptr;
                    fsm_d = SCAN;
                end else if (accept) begin
                    state_d[grant_q] = sync2_q[grant_q];
                    ptr_d            = next_ptr;
                    fsm_d            = SCAN;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: fsm_d = SCAN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q   <= SCAN;
            state_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign sw_o    = state_q;
    assign busy_o  = (fsm_q == COUNT);
    assign grant_o = grant_q;

`ifdef SW_EDGE_PULSE_EN
    logic [NUM_SW-1:0] press_q, press_d, release_q, release_d;

    // Pulses are registered so they land on the same edge as the sw_o update.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        if (accept) begin
            if (sync2_q[grant_q]) press_d[grant_q]   = 1'b1;
            else                  release_d[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
`else
    assign press_o   = '0;
    assign release_o = '0;
`endif

endmodule

// File: tb/tb_switch_debounce_scheduler.sv
// Directed bench for switch_debounce_scheduler with NUM_SW=4, DEBOUNCE_LIMIT=4.
// Pulse expectations follow whether SW_EDGE_PULSE_EN is defined for this build.
module tb_switch_debounce_scheduler;

  localparam int NUM_SW = 4;
  localparam int DL     = 4;

`ifdef SW_EDGE_PULSE_EN
  localparam logic [3:0] PM = 4'hF;
`else
  localparam logic [3:0] PM = 4'h0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_i;
  logic [3:0] sw_o;
  logic [3:0] press_o;
  logic [3:0] release_o;
  logic       busy_o;
  logic [1:0] grant_o;

  int n_cmp;
  int n_err;

  switch_debounce_scheduler #(
    .NUM_SW(NUM_SW),
    .DEBOUNCE_LIMIT(DL)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .sw_i(sw_i),
    .sw_o(sw_o),
    .press_o(press_o),
    .release_o(release_o),
    .busy_o(busy_o),
    .grant_o(grant_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] e_sw, input logic e_busy,
                     input logic [1:0] e_grant, input logic [3:0] e_press, input logic [3:0] e_rel);
    check_eq({tag, ".sw"}, 32'(sw_o), 32'(e_sw));
    check_eq({tag, ".busy"}, 32'(busy_o), 32'(e_busy));
    check_eq({tag, ".grant"}, 32'(grant_o), 32'(e_grant));
    check_eq({tag, ".press"}, 32'(press_o), 32'(e_press & PM));
    check_eq({tag, ".release"}, 32'(release_o), 32'(e_rel & PM));
  endtask

  // Debounce a single accepted change: grant at e2, accept at e6, pulse gone at e7.
  // Called with the input already changed and the bench just after edge e(-1).
  task automatic run_accept(input string tag, input logic [3:0] sw_before, input logic [3:0] sw_after,
                            input logic [1:0] g, input logic [1:0] g_prev, input logic rise);
    logic [3:0] bit_m;
    bit_m = 4'b0001 << g;
    tick(2);
    chk({tag, "@e1"}, sw_before, 1'b0, g_prev, 4'h0, 4'h0);
    tick(1);
    chk({tag, "@e2"}, sw_before, 1'b1, g, 4'h0, 4'h0);
    tick(3);
    chk({tag, "@e5"}, sw_before, 1'b1, g, 4'h0, 4'h0);
    tick(1);
    chk({tag, "@e6"}, sw_after, 1'b0, g, rise ? bit_m : 4'h0, rise ? 4'h0 : bit_m);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sw_i  = 4'hF;

    // 1: reset held with all switches high
    tick(10);
    chk("rst", 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);
    sw_i = 4'h0;
    #3 rst_n = 1'b1;
    tick(3);
    chk("idle", 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);

    // 2: clean rise of switch 1
    sw_i = 4'b0010;
    run_accept("rise1", 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b1);
    tick(1);
    chk("rise1@e7", 4'b0010, 1'b0, 2'd1, 4'h0, 4'h0);

    // 3: switch 0 bounces back after 3 samples; ptr=2 so search 2,3,0
    sw_i = 4'b0011;
    tick(3);
    chk("bnc@e2", 4'b0010, 1'b1, 2'd0, 4'h0, 4'h0);
    sw_i = 4'b0010;
    tick(2);
    chk("bnc@e4", 4'b0010, 1'b1, 2'd0, 4'h0, 4'h0);
    tick(1);
    chk("bnc@e5", 4'b0010, 1'b0, 2'd0, 4'h0, 4'h0);
    tick(3);
    chk("bnc@e8", 4'b0010, 1'b0, 2'd0, 4'h0, 4'h0);

    // 6: async reset mid-COUNT of switch 2, then re-debounce 1 and 2 from scratch
    sw_i = 4'b0110;
    tick(3);
    chk("rc@e2", 4'b0010, 1'b1, 2'd2, 4'h0, 4'h0);
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    chk("rc.async", 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);
    tick(3);
    #3 rst_n = 1'b1;
    run_accept("re1", 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b1);
    tick(1);
    chk("re2@e7", 4'b0010, 1'b1, 2'd2, 4'h0, 4'h0);
    tick(4);
    chk("re2@e11", 4'b0110, 1'b0, 2'd2, 4'b0100, 4'h0);

    // 5: ptr=3; switch 3 rises and switch 1 falls together -> 3 served first
    sw_i = 4'b1100;
    run_accept("s5a", 4'b0110, 4'b1110, 2'd3, 2'd2, 1'b1);
    tick(1);
    chk("s5b@e7", 4'b1110, 1'b1, 2'd1, 4'h0, 4'h0);
    tick(4);
    chk("s5b@e11", 4'b1100, 1'b0, 2'd1, 4'h0, 4'b0010);
    tick(1);
    chk("s5b@e12", 4'b1100, 1'b0, 2'd1, 4'h0, 4'h0);

    // 4: after reset (ptr=0), switches 0 and 2 rise together
    rst_n = 1'b0;
    sw_i  = 4'h0;
    tick(2);
    chk("rst2", 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);
    #3 rst_n = 1'b1;
    tick(1);
    sw_i = 4'b0101;
    run_accept("s4a", 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b1);
    tick(1);
    chk("s4b@e7", 4'b0001, 1'b1, 2'd2, 4'h0, 4'h0);
    tick(3);
    chk("s4b@e10", 4'b0001, 1'b1, 2'd2, 4'h0, 4'h0);
    tick(1);
    chk("s4b@e11", 4'b0101, 1'b0, 2'd2, 4'b0100, 4'h0);
    tick(2);
    chk("s4.idle", 4'b0101, 1'b0, 2'd2, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
